// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared definitions for the program-memory responder.
//
// Contents:
//   DefaultAddrW / DefaultDataW : default address and word widths.
//   ParW                        : parity bits stored per word (1 with PROG_MEM_PARITY_EN, else 0).
//   state_e                     : controller state (StLoad = LOAD, StServe = SERVE).
//
// Configuration macro: PROG_MEM_PARITY_EN (adds one even-parity bit per stored word).

package prog_mem_pkg;

  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned DefaultDataW = 8;

`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned ParW = 1;
`else
  localparam int unsigned ParW = 0;
`endif

  typedef enum logic [0:0] {
    StLoad  = 1'b0,
    StServe = 1'b1
  } state_e;

endpackage

// File: rtl/prog_mem_array.sv
// prog_mem_array: single-write, single-read storage array with no reset.
//
// Writes are synchronous on the rising edge of clk_i when we_i is high. The read port is
// combinational; the owning block registers the read word, so the overall read latency seen by
// the CPU is one cycle. Contents survive reset by design.
//
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write word (Width bits, includes parity when enabled by the owner)
//   raddr_i : read address
//   rdata_o : read word at raddr_i

module prog_mem_array #(
  parameter int unsigned AddrW = 8,
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 256
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mem_responder.sv
// prog_mem_responder: loadable program memory with a registered CPU read port.
//
// After reset the block sits in LOAD and accepts a stream of words (load_valid/load_data/
// load_last), writing them to consecutive addresses from 0. The final word (load_last) or a
// write to address DEPTH-1 moves it to SERVE, where rd_addr is sampled every cycle and the
// addressed word appears on rd_data one cycle later with rd_valid=1. A reload pulse in SERVE
// returns to LOAD with the write pointer cleared. Memory contents are not cleared by reset.
//
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset, highest priority
//   rd_addr      : CPU read address (SERVE)
//   rd_data      : registered read word, 0 while not valid
//   rd_valid     : rd_data holds the word for the address sampled one cycle earlier
//   load_valid   : load_data valid this cycle
//   load_data    : next program word
//   load_last    : current load word is the final one (qualified by load_valid)
//   load_ready   : block accepts load words this cycle (LOAD)
//   reload       : one-cycle request to re-enter LOAD (ignored in LOAD)
//   loaded_words : words written since the last load start
//   par_err      : (PROG_MEM_PARITY_EN only) parity mismatch on the registered read word
//
// Configuration macro: PROG_MEM_PARITY_EN adds per-word even parity and the par_err port.

module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic [ADDR_W:0]   loaded_words
`ifdef PROG_MEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int unsigned MemW = DATA_W + ParW;

  state_e            state_q;
  // One bit wider than the address so a full load ends at DEPTH instead of wrapping to 0.
  // The pointer and the written-word count always move together, so one register serves both.
  logic [ADDR_W:0]   load_ptr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              load_ready_q;

  logic              mem_we;
  logic [MemW-1:0]   mem_wdata;
  logic [MemW-1:0]   mem_rdata;
  logic              at_last_addr;

  // rst gates the write so a reset cycle never stores a word.
  assign mem_we       = (state_q == StLoad) && load_valid && !rst;
  assign at_last_addr = (load_ptr_q == (ADDR_W + 1)'(DEPTH - 1));

`ifdef PROG_MEM_PARITY_EN
  logic par_err_q;

  // Even parity: the stored bit makes the total number of ones in the word even.
  assign mem_wdata = {^load_data, load_data};
`else
  assign mem_wdata = load_data;
`endif

  prog_mem_array #(
    .AddrW (ADDR_W),
    .Width (MemW),
    .Depth (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (load_ptr_q[ADDR_W-1:0]),
    .wdata_i (mem_wdata),
    .raddr_i (rd_addr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      load_ptr_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
          par_err_q  <= 1'b0;
`endif
          // reload is deliberately not looked at here.
          if (load_valid) begin
            load_ptr_q <= load_ptr_q + (ADDR_W + 1)'(1);
            if (load_last || at_last_addr) begin
              state_q      <= StServe;
              load_ready_q <= 1'b0;
            end
          end
        end

        StServe: begin
          if (reload) begin
            state_q      <= StLoad;
            load_ptr_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            load_ready_q <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
            par_err_q    <= 1'b0;
`endif
          end else begin
            // rd_valid rises one cycle after entry: the first SERVE cycle is the first sample.
            rd_data_q  <= mem_rdata[DATA_W-1:0];
            rd_valid_q <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
            par_err_q  <= ^mem_rdata;
`endif
          end
        end
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign load_ready   = load_ready_q;
  assign loaded_words = load_ptr_q;

`ifdef PROG_MEM_PARITY_EN
  assign par_err = par_err_q;
`endif

endmodule
